// File: rtl/snic_responder_pkg.sv
// Shared definitions for the NoC responder: flit types, request field layout,
// burst encodings and FSM state encoding.
package snic_responder_pkg;

  localparam logic [1:0] FT_REQUEST    = 2'd1;
  localparam logic [1:0] FT_RDATA_BODY = 2'd2;

  // Field widths, and offsets measured from the top of the ADDR field (ADDR sits at bit 0).
  localparam int LEN_W     = 4;
  localparam int SIZE_W    = 3;
  localparam int BURST_W   = 2;
  localparam int LEN_OFS   = 0;
  localparam int SIZE_OFS  = LEN_OFS + LEN_W;
  localparam int RW_OFS    = SIZE_OFS + SIZE_W;
  localparam int BURST_OFS = RW_OFS + 1;
  localparam int ID_OFS    = BURST_OFS + BURST_W;

  localparam logic [BURST_W-1:0] BURST_FIXED = 2'b00;
  localparam logic [BURST_W-1:0] BURST_INCR  = 2'b01;
  localparam logic [BURST_W-1:0] BURST_WRAP  = 2'b10;
  localparam logic [BURST_W-1:0] BURST_RSVD  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ISSUE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_RD_SEND
  } state_e;

endpackage

// File: rtl/snic_responder_req_decode.sv
// Combinational slicing of a REQUEST payload into its fields; zero latency, no flow control.
module snic_req_decode
  import snic_responder_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 4,
  parameter int PAYLOAD_W = 78
) (
  input  logic [PAYLOAD_W-1:0] payload,
  output logic [ADDR_W-1:0]    addr,
  output logic [LEN_W-1:0]     len,
  output logic [SIZE_W-1:0]    size,
  output logic                 rw,
  output logic [BURST_W-1:0]   burst,
  output logic [ID_W-1:0]      id,
  output logic [DATA_W-1:0]    wdata
);

  localparam int WDATA_LSB = ADDR_W + ID_OFS + ID_W;

  assign addr  = payload[ADDR_W-1:0];
  assign len   = payload[ADDR_W+LEN_OFS +: LEN_W];
  assign size  = payload[ADDR_W+SIZE_OFS +: SIZE_W];
  assign rw    = payload[ADDR_W+RW_OFS];
  assign burst = payload[ADDR_W+BURST_OFS +: BURST_W];
  assign id    = payload[ADDR_W+ID_OFS +: ID_W];
  assign wdata = payload[WDATA_LSB +: DATA_W];

  if (PAYLOAD_W > WDATA_LSB + DATA_W) begin : g_spare
    logic unused_spare;
    assign unused_spare = ^payload[PAYLOAD_W-1:WDATA_LSB+DATA_W];
  end

endmodule

// File: rtl/snic_responder.sv
// NoC responder: accepts one REQUEST, performs it on the memory port, streams read beats back.
// First mem_req one cycle after accept; read beats stall in RD_SEND while LinkC_Status_in is low.
module snic_responder
  import snic_responder_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int ID_W        = 4,
  parameter int XY_W        = 2,
  parameter int PAYLOAD_W   = 78,
  parameter int FLIT_TYPE_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PAYLOAD_W-1:0]   payload_in,
  input  logic [FLIT_TYPE_W-1:0] flit_type_in,
  input  logic                   payload_in_valid,
  input  logic [2*XY_W-1:0]      R2C_src,
  output logic                   depack_enable,
  output logic [PAYLOAD_W-1:0]   payload_out,
  output logic [FLIT_TYPE_W-1:0] flit_type_out,
  output logic                   pack_enable,
  output logic [4:0]             SN_out,
  output logic [2*XY_W-1:0]      dest,
  input  logic                   LinkC_Status_in,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic                   mem_gnt,
  input  logic                   mem_rvalid,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic                   BUSY,
  output logic [7:0]             drop_cnt
);

  state_e state, state_nxt;

  logic [ADDR_W-1:0]  req_addr;
  logic [LEN_W-1:0]   req_len;
  logic [SIZE_W-1:0]  req_size;
  logic               req_rw;
  logic [BURST_W-1:0] req_burst;
  logic [ID_W-1:0]    req_id;
  logic [DATA_W-1:0]  req_wdata;

  logic [ADDR_W-1:0]  addr_q, addr_step;
  logic [LEN_W-1:0]   len_q;
  logic [SIZE_W-1:0]  size_q;
  logic [BURST_W-1:0] burst_q;
  logic [DATA_W-1:0]  wdata_q, rdata_q;
  logic [4:0]         beat_q;
  logic [2*XY_W-1:0]  dest_q;
  logic [7:0]         drop_q;

  logic is_idle, is_req, accept, drop, send, last_beat;

  // Responses never carry the transaction ID back.
  logic unused_id;
  assign unused_id = ^req_id;

  snic_req_decode #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .ID_W      (ID_W),
    .PAYLOAD_W (PAYLOAD_W)
  ) u_decode (
    .payload (payload_in),
    .addr    (req_addr),
    .len     (req_len),
    .size    (req_size),
    .rw      (req_rw),
    .burst   (req_burst),
    .id      (req_id),
    .wdata   (req_wdata)
  );

  assign is_idle   = (state == ST_IDLE);
  assign is_req    = (flit_type_in == FLIT_TYPE_W'(FT_REQUEST));
  assign accept    = is_idle && payload_in_valid && is_req;
  assign drop      = is_idle && payload_in_valid && !is_req;
  assign send      = (state == ST_RD_SEND) && LinkC_Status_in;
  assign last_beat = (beat_q == {1'b0, len_q});

  // WRAP deliberately behaves as INCR; the reserved encoding behaves as FIXED.
  always_comb begin
    addr_step = addr_q;
    if (burst_q == BURST_INCR || burst_q == BURST_WRAP)
      addr_step = addr_q + (ADDR_W'(1) << size_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    depack_enable = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    pack_enable   = 1'b0;
    flit_type_out = '0;
    payload_out   = '0;
    SN_out        = '0;
    case (state)
      ST_IDLE: begin
        depack_enable = 1'b1;
        if (accept) state_nxt = req_rw ? ST_WR_ISSUE : ST_RD_ISSUE;
      end
      ST_WR_ISSUE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (mem_gnt) state_nxt = ST_IDLE;
      end
      ST_RD_ISSUE: begin
        mem_req  = 1'b1;
        mem_addr = addr_q;
        if (mem_gnt) state_nxt = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (mem_rvalid) state_nxt = ST_RD_SEND;
      end
      ST_RD_SEND: begin
        flit_type_out = FLIT_TYPE_W'(FT_RDATA_BODY);
        payload_out   = PAYLOAD_W'(rdata_q);
        SN_out        = beat_q + 5'd1;
        pack_enable   = LinkC_Status_in;
        if (LinkC_Status_in) state_nxt = last_beat ? ST_IDLE : ST_RD_ISSUE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      beat_q  <= '0;
      dest_q  <= '0;
      drop_q  <= '0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr;
        len_q   <= req_len;
        size_q  <= req_size;
        burst_q <= req_burst;
        wdata_q <= req_wdata;
        dest_q  <= R2C_src;
        beat_q  <= '0;
      end
      if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      // Read data is taken only in RD_WAIT, so an rvalid coincident with the grant is ignored.
      if (state == ST_RD_WAIT && mem_rvalid) rdata_q <= mem_rdata;
      if (send && !last_beat) begin
        beat_q <= beat_q + 5'd1;
        addr_q <= addr_step;
      end
    end
  end

  assign BUSY     = !is_idle;
  assign dest     = dest_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_snic_responder.sv
// Randomized scoreboard bench for snic_responder with a transaction-level reference model.
module tb_snic_responder;
  import snic_responder_pkg::*;

  logic        clk, rst;
  logic [77:0] payload_in, payload_out;
  logic [1:0]  flit_type_in, flit_type_out;
  logic        payload_in_valid, depack_enable, pack_enable, LinkC_Status_in;
  logic [3:0]  R2C_src, dest;
  logic [4:0]  SN_out;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid, BUSY;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  drop_cnt;

  snic_responder dut (
    .clk(clk), .rst(rst), .payload_in(payload_in), .flit_type_in(flit_type_in),
    .payload_in_valid(payload_in_valid), .R2C_src(R2C_src), .depack_enable(depack_enable),
    .payload_out(payload_out), .flit_type_out(flit_type_out), .pack_enable(pack_enable),
    .SN_out(SN_out), .dest(dest), .LinkC_Status_in(LinkC_Status_in), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .BUSY(BUSY), .drop_cnt(drop_cnt)
  );

  typedef struct {logic [4:0] sn; logic [3:0] dst; logic [31:0] data;} fl_t;
  typedef struct {logic [31:0] addr; logic we; logic [31:0] wdata;} mo_t;

  fl_t         exp_fl[$];
  mo_t         exp_mem[$];
  logic [31:0] rdq[$];

  int total = 0, bad = 0, npack = 0, ngnt = 0, exp_drop = 0;
  int g_wait = 0, rv_wait = 0, lk_low = 0;
  bit pend_rd = 0, rv_hold = 0, mem_fast = 0, lk_always = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory slave: random grant delay, one outstanding read, occasional junk rvalid on grant.
  initial begin
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_gnt = 0; mem_rvalid = 0;
      if (!rst) begin
        pend_rd = 0; g_wait = 0;
      end else if (pend_rd) begin
        if (rv_hold) ;
        else if (rv_wait > 0) rv_wait--;
        else begin
          mem_rvalid = 1;
          mem_rdata  = (rdq.size() != 0) ? rdq.pop_front() : 32'h0BAD_0000;
          pend_rd    = 0;
        end
      end else if (mem_req) begin
        if (g_wait > 0) g_wait--;
        else begin
          mem_gnt = 1;
          if (!mem_we) begin
            pend_rd = 1;
            rv_wait = mem_fast ? 0 : $urandom_range(0, 2);
          end
          if (!mem_fast && $urandom_range(0, 3) == 0) begin
            mem_rvalid = 1;
            mem_rdata  = 32'hBAD0_BAD0;
          end
          g_wait = mem_fast ? 0 : $urandom_range(0, 2);
        end
      end
    end
  end

  initial begin
    LinkC_Status_in = 0;
    forever begin
      @(posedge clk); #1;
      if (lk_low > 0) begin
        LinkC_Status_in = 0;
        lk_low--;
      end else if (lk_always) LinkC_Status_in = 1;
      else LinkC_Status_in = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitors: pop and compare whenever the DUT presents a flit or a granted memory access.
  initial begin : mon
    fl_t f;
    mo_t m;
    forever begin
      @(negedge clk);
      if (rst && pack_enable) begin
        npack++;
        chk("pulse_link_high", LinkC_Status_in, 1);
        chk("flit_type_out", flit_type_out, FT_RDATA_BODY);
        chk("flit_expected", exp_fl.size() != 0, 1);
        if (exp_fl.size() != 0) begin
          f = exp_fl.pop_front();
          chk("SN_out", SN_out, f.sn);
          chk("dest", dest, f.dst);
          chk("payload_out", payload_out, 78'(f.data));
        end
      end
      if (rst && mem_req && mem_gnt) begin
        ngnt++;
        chk("memop_expected", exp_mem.size() != 0, 1);
        if (exp_mem.size() != 0) begin
          m = exp_mem.pop_front();
          chk("mem_addr", mem_addr, m.addr);
          chk("mem_we", mem_we, m.we);
          if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_depack_enable"}, depack_enable, 1);
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_pack_enable"}, pack_enable, 0);
    chk({tag, "_sn_out"}, SN_out, 0);
    chk({tag, "_dest"}, dest, 0);
    chk({tag, "_payload_out"}, payload_out, 0);
    chk({tag, "_flit_type_out"}, flit_type_out, 0);
    chk({tag, "_drop_cnt"}, drop_cnt, 0);
  endtask

  // Reference model: expand the request into its memory accesses and response flits.
  task automatic send_req(input logic rw, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [3:0] src,
                          input logic [31:0] wdata, input bit seq, input logic [31:0] base);
    logic [31:0] a, d;
    mo_t m;
    fl_t f;
    a = addr;
    if (rw) begin
      m.addr = addr; m.we = 1; m.wdata = wdata;
      exp_mem.push_back(m);
    end else begin
      for (int b = 0; b <= int'(len); b++) begin
        m.addr = a; m.we = 0; m.wdata = '0;
        exp_mem.push_back(m);
        d = seq ? base + 32'(b) : $urandom;
        rdq.push_back(d);
        f.sn = 5'(b + 1); f.dst = src; f.data = d;
        exp_fl.push_back(f);
        if (burst == 2'b01 || burst == 2'b10) a = a + (32'd1 << size);
      end
    end
    chk("depack_enable_before_req", depack_enable, 1);
    payload_in       = {wdata, 4'($urandom), burst, rw, size, len, addr};
    flit_type_in     = FT_REQUEST;
    R2C_src          = src;
    payload_in_valid = 1;
    tick();
    payload_in_valid = 0;
    chk("depack_enable_after_accept", depack_enable, 0);
    chk("busy_after_accept", BUSY, 1);
    chk("mem_req_one_cycle_after_accept", mem_req, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((BUSY || exp_fl.size() != 0 || exp_mem.size() != 0) && n < 1500) begin
      tick();
      n++;
    end
    chk("done_busy", BUSY, 0);
    chk("done_flits_left", exp_fl.size(), 0);
    chk("done_memops_left", exp_mem.size(), 0);
    chk("done_depack_enable", depack_enable, 1);
    if (n >= 1500) begin
      rst = 0;
      exp_fl.delete(); exp_mem.delete(); rdq.delete();
      tick();
      rst = 1;
      exp_drop = 0;
      tick();
    end
  endtask

  task automatic inject(input int n);
    payload_in_valid = 1;
    flit_type_in     = FT_RDATA_BODY;
    repeat (n) begin
      tick();
      if (exp_drop < 255) exp_drop++;
    end
    payload_in_valid = 0;
  endtask

  initial begin
    int p0, g0, n;
    rst = 0; payload_in = '0; flit_type_in = '0; payload_in_valid = 0; R2C_src = '0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk); rst = 1;
    tick(); tick();

    // Single-beat write, grant after two wait cycles, no response flit.
    p0 = npack;
    g_wait = 2;
    send_req(1, 32'h1000_0010, 4'd5, 3'd2, 2'b01, 4'b0011, 32'hDEADBEEF, 0, 0);
    wait_done();
    chk("write_no_pack", npack, p0);

    // INCR read, four beats with known data.
    send_req(0, 32'h0000_0100, 4'd3, 3'd2, 2'b01, 4'b0110, 32'h0, 1, 32'hA0);
    wait_done();

    // Backpressure on the second beat of a two-beat read.
    lk_always = 1; mem_fast = 1;
    p0 = npack;
    send_req(0, 32'h0000_2000, 4'd1, 3'd2, 2'b01, 4'b1001, 32'h0, 0, 0);
    n = 0;
    while (npack == p0 && n < 100) begin tick(); n++; end
    lk_low = 5;
    wait_done();
    chk("backpressure_pulses", npack, p0 + 2);
    lk_always = 0; mem_fast = 0;

    // FIXED and INCR bursts at the top of the address space.
    send_req(0, 32'hFFFF_FFFC, 4'd15, 3'd2, 2'b00, 4'b1111, 32'h0, 0, 0);
    wait_done();
    send_req(0, 32'hFFFF_FFFC, 4'd15, 3'd2, 2'b01, 4'b0101, 32'h0, 0, 0);
    wait_done();

    // Non-REQUEST flits dropped in IDLE; a request while busy is refused.
    inject(3);
    chk("drop_cnt_three", drop_cnt, exp_drop);
    send_req(0, 32'h0000_0400, 4'd2, 3'd0, 2'b01, 4'b0010, 32'h0, 0, 0);
    payload_in_valid = 1;
    flit_type_in = FT_REQUEST;
    chk("busy_depack_enable", depack_enable, 0);
    tick();
    flit_type_in = FT_RDATA_BODY;
    tick();
    payload_in_valid = 0;
    chk("busy_no_drop", drop_cnt, exp_drop);
    wait_done();
    inject(260);
    chk("drop_cnt_saturate", drop_cnt, exp_drop);

    // Reset in RD_WAIT of an eight-beat read, then a clean read.
    rv_hold = 1;
    g0 = ngnt;
    send_req(0, 32'h0000_3000, 4'd7, 3'd2, 2'b01, 4'b1010, 32'h0, 0, 0);
    n = 0;
    while (ngnt == g0 && n < 50) begin tick(); n++; end
    tick(); #1;
    chk("busy_before_abort", BUSY, 1);
    rst = 0;
    #1;
    check_reset_outputs("abort");
    exp_fl.delete(); exp_mem.delete(); rdq.delete();
    exp_drop = 0;
    rv_hold = 0;
    tick(); tick();
    @(negedge clk); rst = 1;
    tick();
    send_req(0, 32'h0000_0040, 4'd2, 3'd1, 2'b10, 4'b0100, 32'h0, 1, 32'h55);
    wait_done();

    // Random requests against the reference model.
    for (int i = 0; i < 25; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 1) == 1) ? $urandom : (32'hFFFF_FFE0 | 32'($urandom_range(0, 31)));
      send_req(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 3)),
               2'($urandom_range(0, 3)), 4'($urandom), $urandom, 0, 0);
      wait_done();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
